// File: rtl/rv32i_pkg.sv
// Shared types and helpers for the rv32i data-memory responder.
package rv32i_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } resp_state_t;

    // Wait-state counter width; 4 bits covers 0..15.
    localparam int unsigned WAIT_W = 4;

    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_dmem_responder_dmem_array.sv
// Word-organised data RAM: synchronous byte-enabled write, asynchronous read.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (be[k]) mem[addr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    always_comb begin
        rdata = mem[addr];
    end

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Memory-side responder for the core's load/store port: one outstanding
// transaction, programmable wait states, byte-enabled stores, error on illegal access.
module rv32i_dmem_responder
    import rv32i_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

    resp_state_t       state, state_next;
    logic [WAIT_W-1:0] wcnt;

    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;

    logic        c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic [3:0]  c_be;
    logic [31:0] c_off;
    logic        c_legal;
    logic        commit;
    logic        mem_we;
    logic [AW-1:0] mem_idx;
    logic [31:0] mem_rdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // WAIT exits once the counter reaches WAIT_STATES, i.e. after WAIT_STATES+1
    // cycles, so the response appears one cycle plus WAIT_STATES after acceptance.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (req_valid) state_next = (WAIT_STATES != 0) ? WAIT : RESP;
            WAIT: if (wcnt == WAIT_W'(WAIT_STATES)) state_next = RESP;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    // Commit straight from the request bus when IDLE jumps directly to RESP.
    always_comb begin
        if (state == IDLE) begin
            c_we    = req_we;
            c_addr  = req_addr;
            c_wdata = req_wdata;
            c_be    = req_be;
        end else begin
            c_we    = lat_we;
            c_addr  = lat_addr;
            c_wdata = lat_wdata;
            c_be    = lat_be;
        end
        c_legal = (c_addr[1:0] == 2'b00)
               && ({1'b0, c_addr} >= {1'b0, BASE_ADDR})
               && ({1'b0, c_addr} < LIMIT)
               && be_legal(c_be);
        c_off   = c_addr - BASE_ADDR;
        mem_idx = AW'(c_off >> 2);
        commit  = (state != RESP) && (state_next == RESP);
        mem_we  = commit && c_we && c_legal;
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk  (clk),
        .we   (mem_we),
        .be   (c_be),
        .addr (mem_idx),
        .wdata(c_wdata),
        .rdata(mem_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wcnt      <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_valid) begin
                lat_we    <= req_we;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
                lat_be    <= req_be;
                wcnt      <= '0;
            end else if (state == WAIT) begin
                wcnt <= wcnt + 1'b1;
            end
            if (commit) begin
                rsp_err   <= !c_legal;
                rsp_rdata <= (c_legal && !c_we) ? mem_rdata : '0;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Self-checking bench for rv32i_dmem_responder: transaction-level model
// compared against the DUT every cycle, plus directed literal checks.
module tb_rv32i_dmem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int unsigned WS    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    rv32i_dmem_responder #(
        .DEPTH_WORDS(DEPTH),
        .BASE_ADDR  (BASE),
        .WAIT_STATES(WS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_be   (req_be),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    // Transaction-level model state
    logic [31:0] model_mem [int unsigned];
    bit          pending = 0;
    bit          committed = 0;
    bit          rb;
    int          acc_cyc = 0;
    logic        m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic [31:0] exp_rdata = '0;
    bit          exp_err = 0;
    bit          exp_known = 0;
    int          n_acc = 0;
    int          n_hs = 0;
    logic [31:0] last_rdata = '0;
    logic        last_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit legal(input logic [31:0] a, input logic [3:0] be);
        longint unsigned la = longint'(a);
        longint unsigned lo = longint'(BASE);
        longint unsigned hi = longint'(BASE) + 4 * longint'(DEPTH);
        return (a % 4 == 0) && (la >= lo) && (la < hi) &&
               (be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
    endfunction

    task automatic model_commit();
        int unsigned widx;
        logic [31:0] w;
        if (!legal(m_addr, m_be)) begin
            exp_err = 1; exp_rdata = '0; exp_known = 1;
        end else begin
            exp_err = 0;
            widx = (m_addr - BASE) / 4;
            if (m_we) begin
                if (model_mem.exists(widx)) begin
                    w = model_mem[widx];
                    for (int k = 0; k < 4; k++)
                        if (m_be[k]) w[8*k +: 8] = m_wdata[8*k +: 8];
                    model_mem[widx] = w;
                end else if (m_be == 4'b1111) begin
                    model_mem[widx] = m_wdata;
                end
                exp_rdata = '0; exp_known = 1;
            end else begin
                exp_known = model_mem.exists(widx);
                exp_rdata = exp_known ? model_mem[widx] : '0;
            end
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model update at each edge: handshake, then commit, then acceptance
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending   = 0;
            committed = 0;
        end else begin
            rb = !pending;
            if (pending && committed && rsp_ready) begin
                pending = 0; committed = 0; n_hs++;
            end
            if (pending && !committed && (cyc + 1) == acc_cyc + 1 + int'(WS)) begin
                model_commit();
                committed = 1;
            end
            if (rb && req_valid) begin
                m_we = req_we; m_addr = req_addr; m_wdata = req_wdata; m_be = req_be;
                pending = 1; acc_cyc = cyc + 1; n_acc++;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("rst_req_ready", 32'(req_ready), 32'd1);
            check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("rst_rsp_rdata", rsp_rdata, 32'd0);
            check("rst_rsp_err",   32'(rsp_err), 32'd0);
        end else begin
            check("req_ready", 32'(req_ready), 32'(!pending));
            check("rsp_valid", 32'(rsp_valid), 32'(pending && committed));
            if (pending && committed) begin
                check("rsp_err", 32'(rsp_err), 32'(exp_err));
                if (exp_known) check("rsp_rdata", rsp_rdata, exp_rdata);
                if (rsp_ready) begin
                    last_rdata = rsp_rdata;
                    last_err   = rsp_err;
                end
            end
        end
    end

    task automatic junk();
        req_valid = 1'($urandom % 2);
        req_we    = 1'($urandom % 2);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int bp);
        int start_acc = n_acc;
        int start_hs  = n_hs;
        int t;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
        rsp_ready = 1'b0;
        t = 0;
        while (n_acc == start_acc && t < 20) begin @(posedge clk); #1; t++; end
        if (n_acc == start_acc) check("accept_timeout", 32'(t), 32'd0);
        req_valid = 1'b0;
        t = 0;
        while (!(pending && committed) && t < 40) begin junk(); @(posedge clk); #1; t++; end
        if (!(pending && committed)) check("response_timeout", 32'(t), 32'd0);
        repeat (bp) begin junk(); @(posedge clk); #1; end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        t = 0;
        while (n_hs == start_hs && t < 20) begin @(posedge clk); #1; t++; end
        if (n_hs == start_hs) check("handshake_timeout", 32'(t), 32'd0);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
    endtask

    task automatic check_last(input string name, input logic [31:0] rd, input logic err);
        check({name, "_rdata"}, last_rdata, rd);
        check({name, "_err"}, 32'(last_err), 32'(err));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] legal_be [7];
        logic [31:0] a;
        logic [3:0]  b;
        int r;
        legal_be = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

        // Reset held with a request pending: nothing may be accepted
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        req_valid = 1'b0;

        for (int unsigned i = 0; i < 64; i++)
            txn(1'b1, BASE + 4 * i, $urandom, 4'b1111, 0);

        txn(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'b1111, 0);
        check_last("store_ack", 32'h0, 1'b0);
        txn(1'b0, BASE + 32'h10, 32'h0, 4'b1111, 0);
        check_last("load_deadbeef", 32'hDEAD_BEEF, 1'b0);

        txn(1'b1, BASE + 32'h10, 32'h0000_AA00, 4'b0010, 0);
        txn(1'b0, BASE + 32'h10, 32'h0, 4'b1111, 0);
        check_last("byte_lane", 32'hDEAD_AAEF, 1'b0);

        txn(1'b0, BASE + 32'h13, 32'h0, 4'b1111, 0);
        check_last("err_misaligned", 32'h0, 1'b1);
        txn(1'b1, BASE + 32'h10, 32'hFFFF_FFFF, 4'b0101, 0);
        check_last("err_bad_be", 32'h0, 1'b1);
        txn(1'b1, BASE + 4 * DEPTH, 32'hFFFF_FFFF, 4'b1111, 0);
        check_last("err_range", 32'h0, 1'b1);
        txn(1'b0, BASE + 32'h10, 32'h0, 4'b1111, 0);
        check_last("err_no_side_effect", 32'hDEAD_AAEF, 1'b0);

        txn(1'b1, BASE + 32'h14, 32'h1122_3344, 4'b1111, 5);
        txn(1'b0, BASE + 32'h14, 32'h0, 4'b1111, 5);
        check_last("backpressure", 32'h1122_3344, 1'b0);

        txn(1'b1, BASE + 32'h20, 32'h0BAD_F00D, 4'b1111, 0);
        req_we = 1'b1; req_addr = BASE + 32'h20; req_wdata = 32'h1234_5678; req_be = 4'hF;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        txn(1'b0, BASE + 32'h20, 32'h0, 4'b1111, 0);
        check_last("reset_abort", 32'h0BAD_F00D, 1'b0);

        for (int n = 0; n < 200; n++) begin
            r = int'($urandom % 10);
            if (r < 7)       a = BASE + 4 * ($urandom % 64);
            else if (r == 7) a = BASE + 4 * ($urandom % 64) + 1 + ($urandom % 3);
            else if (r == 8) a = BASE + 4 * DEPTH + 4 * ($urandom % 16);
            else             a = 32'hFFFF_FFFC;
            b = ($urandom % 4 != 0) ? legal_be[$urandom % 7] : 4'($urandom);
            txn(1'($urandom % 2), a, $urandom, b, int'($urandom % 4));
        end

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
